fb_sram_arbiter: RTL
====================

Name: fb_sram_arbiter

Overview:
Shares the single-port external SRAM frame buffer between two requesters: the display fetch path, which reads pixel words for the VGA scan-out, and the draw engine, which writes pixels. Display reads have priority. A starvation guard makes sure writes still complete. The block owns every SRAM control pin. Its registered, glitch-free outputs go straight to the pads.

Parameters:
ADDR_W, 20, SRAM word address width
DATA_W, 16, SRAM data width
STARVE_LIMIT, 8, consecutive read grants allowed while a write is pending before the write is forced

Ports:
Clk  in  1  50 MHz system clock
Reset_N  in  1  asynchronous, active-low reset
rd_req  in  1  display read request; hold with stable rd_addr until rd_gnt
rd_addr  in  ADDR_W  read word address
rd_gnt  out  1  one-cycle pulse: read accepted
rd_data  out  DATA_W  read data
rd_valid  out  1  one-cycle pulse: rd_data valid
wr_req  in  1  draw write request; hold with stable wr_addr/wr_data until wr_gnt
wr_addr  in  ADDR_W  write word address
wr_data  in  DATA_W  write data
wr_gnt  out  1  one-cycle pulse: write accepted
SRAM_ADDR  out  ADDR_W  SRAM address
SRAM_DQ_out  out  DATA_W  data driven to pad
SRAM_DQ_oe  out  1  pad output enable, high = drive
SRAM_DQ_in  in  DATA_W  data from pad
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes
busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. Reset is asynchronous and applies immediately, including mid-access:
  - state = IDLE
  - CE_N/OE_N/WE_N/UB_N/LB_N = 1
  - DQ_oe = 0; SRAM_ADDR = 0; DQ_out = 0
  - rd_gnt/wr_gnt/rd_valid = 0; rd_data = 0
  - starvation counter = 0
- FSM states: IDLE, RD_ACC, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD.
- Arbitration happens only in IDLE, RD_CAP and WR_HOLD, which are the arbitration points.
- Winner selection:
  - rd_req only -> read.
  - wr_req only -> write.
  - Both -> read, unless starve_cnt == STARVE_LIMIT, in which case write.
  - Neither -> IDLE.
- Read, arbitrated in cycle n:
  - n+1: RD_ACC. rd_gnt=1, SRAM_ADDR=rd_addr, CE_N=0, OE_N=0, UB_N=LB_N=0, DQ_oe=0.
  - n+2: RD_CAP. Strobes held; SRAM_DQ_in is sampled at the end of this cycle.
  - n+3: rd_valid=1 with rd_data. rd_data holds until the next capture.
  - Latency from grant to valid is exactly 2 cycles.
- Write, arbitrated in cycle n:
  - n+1: WR_SETUP. wr_gnt=1, SRAM_ADDR=wr_addr, DQ_out=wr_data, DQ_oe=1, CE_N=0, WE_N=1, OE_N=1.
  - n+2: WR_PULSE. WE_N=0.
  - n+3: WR_HOLD. WE_N=1; address, data, DQ_oe and CE_N unchanged.
  - WE_N is low for exactly one cycle. Address and data are stable from one cycle before WE_N falls to one cycle after it rises.
- Idle conditions:
  - In IDLE, CE_N=OE_N=WE_N=1 and DQ_oe=0; SRAM_ADDR holds its last value.
  - DQ_oe and OE_N are never both active. Leaving WR_HOLD for RD_ACC clears DQ_oe in the same edge that lowers OE_N; the SRAM's tOE gives bus turnaround margin.
- Throughput: back-to-back reads run one grant every 2 cycles (RD_ACC/RD_CAP alternating); writes run one every 3 cycles.
- Starvation counter:
  - Saturating, width $clog2(STARVE_LIMIT+1).
  - Increments on each read grant made while wr_req=1.
  - Clears on a write grant, and in any cycle where wr_req=0.
- A requester may drop its req before it receives a grant (withdrawal). The arbiter only samples at arbitration points; no grant is ever issued for a req that was low at that point.
- Grants are one-hot; rd_gnt and wr_gnt are never high in the same cycle.

Decomposition:
- fb_pkg holds:
  - the fb_state_t enum (six states)
  - FB_ADDR_W = 20, FB_DATA_W = 16
  - the SRAM strobe idle-value constants
- Single module; no sub-module. The priority/starvation logic is a small always_comb next to the FSM.

Test Plan:
1. Reset: hold Reset_N=0 with rd_req=wr_req=1 -> all strobes 1, DQ_oe=0, no grants. Release -> the first rd_gnt appears 1 cycle after the first arbitration edge.
2. Single read: rd_addr=0x00123, model drives 0xBEEF during RD_CAP -> rd_gnt at n+1; OE_N=0 for 2 cycles; rd_valid at n+3 with rd_data=0xBEEF.
3. Single write: wr_addr=0x00456, wr_data=0xA5A5 -> wr_gnt at n+1; WE_N=0 only at n+2; ADDR=0x00456 and DQ_out=0xA5A5 with DQ_oe=1 from n+1 through n+3.
4. Contention with STARVE_LIMIT=8 and both reqs held continuously -> 8 read grants spaced 2 cycles apart, then 1 write grant, then reads resume with starve_cnt back to 0.
5. Reset_N pulsed low during WR_PULSE -> WE_N=1 and DQ_oe=0 asynchronously, before the next Clk edge. After release, the still-held wr_req is re-granted and the full write sequence repeats.
6. Four back-to-back reads to 0x0,0x1,0x2,0x3 returning 0x10..0x13 -> rd_gnt every 2 cycles; rd_valid pulses in order with matching data; OE_N stays 0 throughout.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer SRAM arbiter.
package fb_pkg;
  localparam int FB_ADDR_W = 20;
  localparam int FB_DATA_W = 16;

  // SRAM strobes are active-low; idle means deasserted.
  localparam logic STROBE_IDLE = 1'b1;
  localparam logic STROBE_ACT  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    RD_CAP,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } fb_state_t;
endpackage

// File: rtl/fb_sram_arbiter.sv
// Read-priority arbiter for the single-port frame-buffer SRAM; 2-cycle grant-to-data reads, 3-cycle writes.
// Requesters hold req until grant; a starvation counter forces a write after STARVE_LIMIT contended reads.
module fb_sram_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W       = FB_ADDR_W,
  parameter int DATA_W       = FB_DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_DQ_out,
  output logic              SRAM_DQ_oe,
  input  logic [DATA_W-1:0] SRAM_DQ_in,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N,
  output logic              busy
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  fb_state_t         state, state_nxt;
  logic [CNT_W-1:0]  starve_cnt;
  logic              arb_point, pick_rd, pick_wr;

  logic              rd_gnt_nxt, wr_gnt_nxt, rd_valid_nxt, dq_oe_nxt, busy_nxt;
  logic              ce_n_nxt, oe_n_nxt, we_n_nxt, ub_n_nxt, lb_n_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] dq_out_nxt, rd_data_nxt;

  assign arb_point = (state == IDLE) || (state == RD_CAP) || (state == WR_HOLD);

  always_comb begin
    pick_rd = 1'b0;
    pick_wr = 1'b0;
    if (arb_point) begin
      if (rd_req && !(wr_req && starve_cnt == CNT_MAX)) pick_rd = 1'b1;
      else if (wr_req)                                 pick_wr = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RD_ACC:   state_nxt = RD_CAP;
      WR_SETUP: state_nxt = WR_PULSE;
      WR_PULSE: state_nxt = WR_HOLD;
      default: begin
        if (pick_rd)      state_nxt = RD_ACC;
        else if (pick_wr) state_nxt = WR_SETUP;
        else              state_nxt = IDLE;
      end
    endcase
  end

  // Pad-facing values are computed for the next state and registered, so pins never glitch.
  always_comb begin
    rd_gnt_nxt   = (state_nxt == RD_ACC) && arb_point;
    wr_gnt_nxt   = (state_nxt == WR_SETUP) && arb_point;
    addr_nxt     = SRAM_ADDR;
    dq_out_nxt   = SRAM_DQ_out;
    if (rd_gnt_nxt) addr_nxt = rd_addr;
    if (wr_gnt_nxt) begin
      addr_nxt   = wr_addr;
      dq_out_nxt = wr_data;
    end
    dq_oe_nxt    = (state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) || (state_nxt == WR_HOLD);
    busy_nxt     = (state_nxt != IDLE);
    ce_n_nxt     = busy_nxt ? STROBE_ACT : STROBE_IDLE;
    ub_n_nxt     = ce_n_nxt;
    lb_n_nxt     = ce_n_nxt;
    oe_n_nxt     = ((state_nxt == RD_ACC) || (state_nxt == RD_CAP)) ? STROBE_ACT : STROBE_IDLE;
    we_n_nxt     = (state_nxt == WR_PULSE) ? STROBE_ACT : STROBE_IDLE;
    rd_valid_nxt = (state == RD_CAP);
    rd_data_nxt  = (state == RD_CAP) ? SRAM_DQ_in : rd_data;
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      rd_gnt      <= 1'b0;
      wr_gnt      <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_out <= '0;
      SRAM_DQ_oe  <= 1'b0;
      SRAM_CE_N   <= STROBE_IDLE;
      SRAM_OE_N   <= STROBE_IDLE;
      SRAM_WE_N   <= STROBE_IDLE;
      SRAM_UB_N   <= STROBE_IDLE;
      SRAM_LB_N   <= STROBE_IDLE;
      busy        <= 1'b0;
    end else begin
      rd_gnt      <= rd_gnt_nxt;
      wr_gnt      <= wr_gnt_nxt;
      rd_valid    <= rd_valid_nxt;
      rd_data     <= rd_data_nxt;
      SRAM_ADDR   <= addr_nxt;
      SRAM_DQ_out <= dq_out_nxt;
      SRAM_DQ_oe  <= dq_oe_nxt;
      SRAM_CE_N   <= ce_n_nxt;
      SRAM_OE_N   <= oe_n_nxt;
      SRAM_WE_N   <= we_n_nxt;
      SRAM_UB_N   <= ub_n_nxt;
      SRAM_LB_N   <= lb_n_nxt;
      busy        <= busy_nxt;
    end
  end

  // Only contended read grants count; any cycle without a pending write resets the guard.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N)                            starve_cnt <= '0;
    else if (!wr_req || pick_wr)             starve_cnt <= '0;
    else if (pick_rd && starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
  end
endmodule
